axis_channel_averager: RTL and testbench
========================================

AXIS_CHANNEL_AVERAGER -- requirements
Module: axis_channel_averager

Interface
REQ-001: Parameter AXIS_TDATA_WIDTH, default 32, stream width: two signed channels of AXIS_TDATA_WIDTH/2 bits each, channel A in the upper half, channel B in the lower half.
REQ-002: Parameter LOG2_MAX_RATIO, default 8, largest supported log2 of the averaging ratio.
REQ-003: aclk  input  1  sole clock; all logic is on its rising edge.
REQ-004: reset  input  1  reset, synchronous and active-high.
REQ-005: log2_ratio  input  $clog2(LOG2_MAX_RATIO+1)  requested k; block length N = 2^k beats.
REQ-006: S_AXIS_tdata  input  AXIS_TDATA_WIDTH  packed two-channel input sample.
REQ-007: S_AXIS_tvalid  input  1  input beat valid.
REQ-008: S_AXIS_tready  output  1  input beat accepted when high with tvalid.
REQ-009: M_AXIS_tready  input  1  downstream ready.
REQ-010: M_AXIS_tdata  output  AXIS_TDATA_WIDTH  packed averaged sample, same channel layout as the input.
REQ-011: M_AXIS_tvalid  output  1  output beat valid.

Function
REQ-012: Input accept = S_AXIS_tvalid && S_AXIS_tready; output transfer = M_AXIS_tvalid && M_AXIS_tready.
REQ-013: Each channel has its own signed accumulator of AXIS_TDATA_WIDTH/2 + LOG2_MAX_RATIO bits, and the input half is sign-extended before addition; accumulators never overflow.
REQ-014: The beat counter runs 0..N-1. The first accepted beat of a block (count == 0) loads the accumulators with the beat value instead of adding it.
REQ-015: k is latched from log2_ratio on the first accepted beat of each block; changes to log2_ratio mid-block have no effect until the next block.
REQ-016: log2_ratio values above LOG2_MAX_RATIO are clamped to LOG2_MAX_RATIO when latched.
REQ-017: On the beat that completes a block (count == N-1), the output register is loaded with (accumulator + beat) >>> k per channel, arithmetic shift, truncated to AXIS_TDATA_WIDTH/2 bits. This truncates toward negative infinity; there is no rounding.
REQ-018: On that same beat M_AXIS_tvalid goes high on the next clock edge, giving one cycle of latency from the final input beat to the output. The counter returns to 0.
REQ-019: For k = 0 every accepted beat completes a block: the output equals the input, delayed by one cycle.
REQ-020: S_AXIS_tready is low only when count == N-1 (using the latched k, or the clamped log2_ratio when count == 0), M_AXIS_tvalid is high and M_AXIS_tready is low. Otherwise it is high, so non-final beats are accepted even while the output is stalled.
REQ-021: When an output transfer and a new completing beat occur in the same cycle, the output register is reloaded and M_AXIS_tvalid stays high. No bubble and no loss occur.
REQ-022: M_AXIS_tvalid and M_AXIS_tdata remain stable while M_AXIS_tvalid && !M_AXIS_tready.
REQ-023: An output transfer with no completing beat clears M_AXIS_tvalid on the next edge.
REQ-024: S_AXIS_tready is combinational from M_AXIS_tvalid, M_AXIS_tready and internal state. There is no combinational path from S_AXIS_tdata to any output.

Reset
REQ-025: While reset is high at a clock edge: M_AXIS_tvalid = 0, M_AXIS_tdata = 0, counter = 0, accumulators = 0, latched k = 0.
REQ-026: The first beat accepted after reset deasserts starts a new block. A reset mid-block discards the partial sums and any pending output beat.
REQ-027: S_AXIS_tready is 0 while reset is high.

Verification
REQ-028: k=0, inputs 0x0001FFFF then 0x7FFF8000, with M_AXIS_tready=1 -> outputs 0x0001FFFF then 0x7FFF8000, each one cycle after acceptance, and S_AXIS_tready held at 1.
REQ-029: k=2, four beats with A = 1,2,3,4 and B = -1,-2,-3,-4, continuous valid -> a single output A = 0x0002, B = 0xFFFD (sums 10 and -10, >>>2), valid on the cycle after the 4th beat.
REQ-030: k=3, eight beats of 0x7FFF7FFF then eight beats of 0x80008000 -> outputs 0x7FFF7FFF then 0x80008000 (no overflow).
REQ-031: k=1, M_AXIS_tready held 0 after the first output -> beat 3 accepted, beat 4 stalls (S_AXIS_tready=0), first output held stable; M_AXIS_tready raised -> first output transfers, beat 4 accepted in the same cycle, second output valid next cycle with no gap.
REQ-032: log2_ratio changed from 2 to 1 after beat 2 of a block -> the current block still averages 4 beats; the next block averages 2. log2_ratio = 15 with LOG2_MAX_RATIO = 8 -> 256-beat blocks.
REQ-033: Reset asserted after 3 of 4 beats with k=2 -> no output. After release, 4 new beats of A=B=8 -> output 0x00080008.

Source files
------------

// File: rtl/axis_channel_averager.sv
// Two-channel AXI-Stream block averager: sums 2^k signed beats per channel and
// emits (sum >>> k) once per block through a single registered output slot.

module axis_channel_averager_lane #(
  parameter int HALF           = 16,
  parameter int LOG2_MAX_RATIO = 8,
  parameter int KW             = 4
) (
  input  logic            aclk,
  input  logic            reset,
  input  logic            accept,
  input  logic            first,
  input  logic            last,
  input  logic [KW-1:0]   k,
  input  logic [HALF-1:0] din,
  output logic [HALF-1:0] dout
);
  localparam int ACC_W = HALF + LOG2_MAX_RATIO;

  logic signed [ACC_W-1:0] acc_q, acc_d, sum;
  logic        [HALF-1:0]  out_q, out_d;

  always_comb begin
    // The first beat of a block replaces the stale sum rather than adding to it.
    sum   = (first ? '0 : acc_q) + {{LOG2_MAX_RATIO{din[HALF-1]}}, din};
    acc_d = acc_q;
    out_d = out_q;
    if (accept) begin
      acc_d = sum;
      if (last) out_d = HALF'(sum >>> k);
    end
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      acc_q <= '0;
      out_q <= '0;
    end else begin
      acc_q <= acc_d;
      out_q <= out_d;
    end
  end

  assign dout = out_q;
endmodule

module axis_channel_averager #(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int LOG2_MAX_RATIO   = 8
) (
  input  logic                                 aclk,
  input  logic                                 reset,
  input  logic [$clog2(LOG2_MAX_RATIO+1)-1:0]  log2_ratio,
  input  logic [AXIS_TDATA_WIDTH-1:0]          S_AXIS_tdata,
  input  logic                                 S_AXIS_tvalid,
  output logic                                 S_AXIS_tready,
  input  logic                                 M_AXIS_tready,
  output logic [AXIS_TDATA_WIDTH-1:0]          M_AXIS_tdata,
  output logic                                 M_AXIS_tvalid
);
  localparam int HALF   = AXIS_TDATA_WIDTH / 2;
  localparam int KW     = $clog2(LOG2_MAX_RATIO + 1);
  localparam int CNT_W  = (LOG2_MAX_RATIO > 0) ? LOG2_MAX_RATIO : 1;
  localparam int NUM_CH = 2;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [KW-1:0]    k_q, k_d, k_clamp, k_eff;
  logic             vld_q, vld_d;
  logic [CNT_W:0]   blk_len;
  logic             first, last, s_ready, accept;

  logic [NUM_CH-1:0][HALF-1:0] in_ch, out_ch;

  assign in_ch = S_AXIS_tdata;

  always_comb begin
    k_clamp = (log2_ratio > KW'(LOG2_MAX_RATIO)) ? KW'(LOG2_MAX_RATIO) : log2_ratio;
    first   = (cnt_q == '0);
    // At a block boundary k is not latched yet, so the live request decides.
    k_eff   = first ? k_clamp : k_q;
    blk_len = (CNT_W+1)'(1) << k_eff;
    last    = ({1'b0, cnt_q} == (blk_len - (CNT_W+1)'(1)));
    s_ready = !reset && !(last && vld_q && !M_AXIS_tready);
    accept  = S_AXIS_tvalid && s_ready;

    cnt_d = cnt_q;
    k_d   = k_q;
    vld_d = vld_q;
    if (accept) begin
      cnt_d = last ? '0 : cnt_q + CNT_W'(1);
      if (first) k_d = k_clamp;
    end
    if (accept && last)  vld_d = 1'b1;
    else if (M_AXIS_tready) vld_d = 1'b0;
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      cnt_q <= '0;
      k_q   <= '0;
      vld_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      k_q   <= k_d;
      vld_q <= vld_d;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    axis_channel_averager_lane #(
      .HALF           (HALF),
      .LOG2_MAX_RATIO (LOG2_MAX_RATIO),
      .KW             (KW)
    ) u_lane (
      .aclk   (aclk),
      .reset  (reset),
      .accept (accept),
      .first  (first),
      .last   (last),
      .k      (k_eff),
      .din    (in_ch[c]),
      .dout   (out_ch[c])
    );
  end

  assign S_AXIS_tready = s_ready;
  assign M_AXIS_tvalid = vld_q;
  assign M_AXIS_tdata  = out_ch;
endmodule

// File: tb/tb_axis_channel_averager.sv
// Directed bench for axis_channel_averager: expected outputs queued at stimulus
// time, popped and compared by a monitor on every output transfer.

module tb_axis_channel_averager;
  logic        aclk = 1'b0;
  logic        reset;
  logic [3:0]  log2_ratio;
  logic [31:0] S_AXIS_tdata;
  logic        S_AXIS_tvalid;
  logic        S_AXIS_tready;
  logic        M_AXIS_tready;
  logic [31:0] M_AXIS_tdata;
  logic        M_AXIS_tvalid;

  logic [31:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  axis_channel_averager #(.AXIS_TDATA_WIDTH(32), .LOG2_MAX_RATIO(8)) dut (
    .aclk          (aclk),
    .reset         (reset),
    .log2_ratio    (log2_ratio),
    .S_AXIS_tdata  (S_AXIS_tdata),
    .S_AXIS_tvalid (S_AXIS_tvalid),
    .S_AXIS_tready (S_AXIS_tready),
    .M_AXIS_tready (M_AXIS_tready),
    .M_AXIS_tdata  (M_AXIS_tdata),
    .M_AXIS_tvalid (M_AXIS_tvalid)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge aclk) begin
    if (!reset && M_AXIS_tvalid && M_AXIS_tready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_out: got %h expected no output", M_AXIS_tdata);
      end else begin
        chk("out", M_AXIS_tdata, exp_q.pop_front());
      end
    end
  end

  // Present one beat, wait (bounded) for acceptance, return #1 after that edge.
  task automatic send(input logic [31:0] d);
    int t = 0;
    S_AXIS_tdata  = d;
    S_AXIS_tvalid = 1'b1;
    @(negedge aclk);
    while (!S_AXIS_tready && t < 200) begin
      @(negedge aclk);
      t++;
    end
    if (t >= 200) chk("send_timeout", 32'(S_AXIS_tready), 32'd1);
    @(posedge aclk);
    #1;
    S_AXIS_tvalid = 1'b0;
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; log2_ratio = 4'd0; S_AXIS_tdata = '0; S_AXIS_tvalid = 1'b0;
    M_AXIS_tready = 1'b1;
    repeat (3) tick();
    @(negedge aclk);
    chk("rst_tvalid", 32'(M_AXIS_tvalid), 32'd0);
    chk("rst_tdata",  M_AXIS_tdata, 32'h0);
    chk("rst_tready", 32'(S_AXIS_tready), 32'd0);
    tick();
    reset = 1'b0;

    // k=0 pass-through, one cycle latency
    exp_q.push_back(32'h0001FFFF);
    send(32'h0001FFFF);
    chk("k0_vld1", 32'(M_AXIS_tvalid), 32'd1);
    chk("k0_dat1", M_AXIS_tdata, 32'h0001FFFF);
    chk("k0_rdy1", 32'(S_AXIS_tready), 32'd1);
    exp_q.push_back(32'h7FFF8000);
    send(32'h7FFF8000);
    chk("k0_vld2", 32'(M_AXIS_tvalid), 32'd1);
    chk("k0_dat2", M_AXIS_tdata, 32'h7FFF8000);
    chk("k0_rdy2", 32'(S_AXIS_tready), 32'd1);
    tick();
    chk("k0_clear", 32'(M_AXIS_tvalid), 32'd0);

    // k=2: A=1..4, B=-1..-4
    log2_ratio = 4'd2;
    exp_q.push_back(32'h0002FFFD);
    for (int i = 1; i <= 4; i++) begin
      send({16'(i), 16'(-i)});
      if (i == 3) chk("k2_novld", 32'(M_AXIS_tvalid), 32'd0);
    end
    chk("k2_vld", 32'(M_AXIS_tvalid), 32'd1);
    tick();

    // k=3 extremes
    log2_ratio = 4'd3;
    exp_q.push_back(32'h7FFF7FFF);
    repeat (8) send(32'h7FFF7FFF);
    exp_q.push_back(32'h80008000);
    repeat (8) send(32'h80008000);
    tick();

    // k=1 backpressure: (2+4)/2=3, (10+20)/2=15
    log2_ratio = 4'd1;
    M_AXIS_tready = 1'b0;
    exp_q.push_back(32'h00030003);
    exp_q.push_back(32'h000F000F);
    send(32'h00020002);
    send(32'h00040004);
    send(32'h000A000A);
    chk("bp_hold_vld", 32'(M_AXIS_tvalid), 32'd1);
    chk("bp_hold_dat", M_AXIS_tdata, 32'h00030003);
    S_AXIS_tdata = 32'h00140014;
    S_AXIS_tvalid = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge aclk);
      chk("bp_stall_rdy", 32'(S_AXIS_tready), 32'd0);
      chk("bp_stall_vld", 32'(M_AXIS_tvalid), 32'd1);
      chk("bp_stall_dat", M_AXIS_tdata, 32'h00030003);
      tick();
    end
    M_AXIS_tready = 1'b1;
    @(negedge aclk);
    chk("bp_release_rdy", 32'(S_AXIS_tready), 32'd1);
    tick();
    S_AXIS_tvalid = 1'b0;
    chk("bp_next_vld", 32'(M_AXIS_tvalid), 32'd1);
    chk("bp_next_dat", M_AXIS_tdata, 32'h000F000F);
    tick();

    // ratio change mid-block: (4+8+12+16)/4=10, then (6+9)/2=7
    log2_ratio = 4'd2;
    exp_q.push_back(32'h000A000A);
    exp_q.push_back(32'h00070007);
    send(32'h00040004);
    send(32'h00080008);
    log2_ratio = 4'd1;
    send(32'h000C000C);
    chk("mid_novld", 32'(M_AXIS_tvalid), 32'd0);
    send(32'h00100010);
    send(32'h00060006);
    send(32'h00090009);
    tick();

    // log2_ratio=15 clamps to 256 beats: A=0..255 -> 127, B=-(0..255) -> -128
    log2_ratio = 4'd15;
    for (int i = 0; i < 256; i++) begin
      if (i == 255) begin
        chk("clamp_novld", 32'(M_AXIS_tvalid), 32'd0);
        exp_q.push_back(32'h007FFF80);
      end
      send({16'(i), 16'(-i)});
    end
    chk("clamp_vld", 32'(M_AXIS_tvalid), 32'd1);
    tick();

    // reset mid-block discards partial sums
    log2_ratio = 4'd2;
    repeat (3) send(32'h00640064);
    reset = 1'b1;
    @(negedge aclk);
    chk("mrst_rdy", 32'(S_AXIS_tready), 32'd0);
    tick();
    reset = 1'b0;
    @(negedge aclk);
    chk("mrst_vld", 32'(M_AXIS_tvalid), 32'd0);
    tick();
    exp_q.push_back(32'h00080008);
    repeat (4) send(32'h00080008);
    repeat (3) tick();

    chk("drain", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
